// File: rtl/apb_i2s_pkg.sv
// apb_i2s_pkg: shared types, defaults and helpers for the apb_i2s receive path.
package apb_i2s_pkg;
   localparam int DATA_W_DEF = 16;
   typedef enum logic [1:0] {DISABLED, ALIGN, LEFT, RIGHT} state_t;
   function automatic int norm_wlen(input int wlen, input int data_w);
      return (wlen == 0 || wlen > data_w) ? data_w : wlen;
   endfunction
endpackage

// File: rtl/signal_sync.sv
// signal_sync: two-flop synchronizer for one asynchronous input pin.
module signal_sync (
   input  logic clk,
   input  logic nrst,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) {q, meta} <= 2'b00;
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/i2s_rx_framer.sv
// i2s_rx_framer: I2S slave receiver that aligns to WS, deserializes L/R words
// and hands complete stereo pairs to a valid/ready consumer.
module i2s_rx_framer
   import apb_i2s_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int WL_W   = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              i_en,
   input  logic [WL_W-1:0]   i_wlen,
   input  logic              i_sck,
   input  logic              i_ws,
   input  logic              i_sd,
   output logic [DATA_W-1:0] o_data_l,
   output logic [DATA_W-1:0] o_data_r,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_ovf,
   output logic              o_err,
   input  logic              i_clr
);
   logic sck_s, sck_d, sck_pe, ws_s, sd_s;
   state_t state, state_n;
   logic [WL_W-1:0] cnt, cnt_n, cnt_a, wlen_q, wlen_n, wl_norm;
   logic [DATA_W-1:0] sh, sh_n, sh_a, word, hold_l, hold_n, dl_n, dr_n;
   logic ws_prev, ws_prev_n, ws_chg, take, short, valid_n, ovf_set, err_set;

   signal_sync u_sck (.clk(clk), .nrst(nrst), .d(i_sck), .q(sck_s));
   signal_sync u_ws  (.clk(clk), .nrst(nrst), .d(i_ws),  .q(ws_s));
   signal_sync u_sd  (.clk(clk), .nrst(nrst), .d(i_sd),  .q(sd_s));

   assign wl_norm = WL_W'(norm_wlen(int'(i_wlen), DATA_W));
   assign ws_chg  = ws_s != ws_prev;
   assign take    = sck_pe && (state == LEFT || state == RIGHT) && cnt < wlen_q;
   assign sh_a    = take ? {sh[DATA_W-2:0], sd_s} : sh;
   assign cnt_a   = take ? cnt + WL_W'(1) : cnt;
   assign short   = cnt_a < wlen_q;
   // a short slot is left-aligned into wlen bits, zero-filled below
   assign word    = short ? sh_a << (wlen_q - cnt_a) : sh_a;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      sh_n      = sh;
      ws_prev_n = ws_prev;
      wlen_n    = wlen_q;
      hold_n    = hold_l;
      dl_n      = o_data_l;
      dr_n      = o_data_r;
      valid_n   = o_valid & ~i_ready;
      ovf_set   = 1'b0;
      err_set   = 1'b0;
      if (!i_en) begin
         state_n   = DISABLED;
         cnt_n     = '0;
         sh_n      = '0;
         ws_prev_n = 1'b0;
         valid_n   = 1'b0;
      end else begin
         case (state)
            DISABLED: state_n = ALIGN;
            ALIGN: if (sck_pe) begin
               ws_prev_n = ws_s;
               if (!ws_s && ws_prev) begin
                  state_n = LEFT;
                  cnt_n   = '0;
                  sh_n    = '0;
                  wlen_n  = wl_norm;
               end
            end
            default: if (sck_pe) begin
               ws_prev_n = ws_s;
               cnt_n     = cnt_a;
               sh_n      = sh_a;
               if (ws_chg) begin
                  err_set = short;
                  cnt_n   = '0;
                  sh_n    = '0;
                  wlen_n  = wl_norm;
                  if (state == LEFT) begin
                     hold_n  = word;
                     state_n = RIGHT;
                  end else begin
                     state_n = LEFT;
                     if (!o_valid || i_ready) begin
                        dl_n    = hold_l;
                        dr_n    = word;
                        valid_n = 1'b1;
                     end else ovf_set = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         sck_d    <= 1'b0;
         sck_pe   <= 1'b0;
         state    <= DISABLED;
         cnt      <= '0;
         sh       <= '0;
         ws_prev  <= 1'b0;
         wlen_q   <= '0;
         hold_l   <= '0;
         o_data_l <= '0;
         o_data_r <= '0;
         o_valid  <= 1'b0;
         o_ovf    <= 1'b0;
         o_err    <= 1'b0;
      end else begin
         sck_d    <= sck_s;
         sck_pe   <= sck_s & ~sck_d;
         state    <= state_n;
         cnt      <= cnt_n;
         sh       <= sh_n;
         ws_prev  <= ws_prev_n;
         wlen_q   <= wlen_n;
         hold_l   <= hold_n;
         o_data_l <= dl_n;
         o_data_r <= dr_n;
         o_valid  <= valid_n;
         o_ovf    <= ovf_set | (o_ovf & ~i_clr);
         o_err    <= err_set | (o_err & ~i_clr);
      end
endmodule

// File: tb/tb_i2s_rx_framer.sv
// tb_i2s_rx_framer: drives I2S bit streams into i2s_rx_framer and checks the
// received pairs and flags against a word-level model.
module tb_i2s_rx_framer;
   localparam int DW = 16;
   localparam int WLW = 5;
   logic clk = 0, nrst = 0, i_en = 0, i_sck = 0, i_ws = 0, i_sd = 0, i_ready = 0, i_clr = 0;
   logic [WLW-1:0] i_wlen = 16;
   logic [DW-1:0] o_data_l, o_data_r;
   logic o_valid, o_ovf, o_err;
   int n_vec = 0, n_err = 0, rdy_mode = 1, n_got = 0, base = 0;
   logic [31:0] got_l [256], got_r [256];
   logic [31:0] exp_l [$], exp_r [$];
   bit ws_q [$], sd_q [$];
   bit sd_prev = 0;

   i2s_rx_framer #(.DATA_W(DW)) dut (
      .clk(clk), .nrst(nrst), .i_en(i_en), .i_wlen(i_wlen), .i_sck(i_sck), .i_ws(i_ws),
      .i_sd(i_sd), .o_data_l(o_data_l), .o_data_r(o_data_r), .o_valid(o_valid),
      .i_ready(i_ready), .o_ovf(o_ovf), .o_err(o_err), .i_clr(i_clr)
   );

   always #5 clk = ~clk;

   // consumer: decides i_ready for the coming edge and records accepted pairs
   initial forever begin
      @(negedge clk);
      i_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
      if (o_valid && i_ready && n_got < 256) begin
         got_l[n_got] = 32'(o_data_l);
         got_r[n_got] = 32'(o_data_r);
         n_got++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int eff_wlen(input int w);
      return (w == 0 || w > DW) ? DW : w;
   endfunction

   function automatic logic [31:0] model(input logic [31:0] v, input int n, input int w);
      int we = eff_wlen(w);
      return n >= we ? v >> (n - we) : v << (we - n);
   endfunction

   task automatic add_slot(input bit ws, input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         ws_q.push_back(ws);
         sd_q.push_back(v[i]);
      end
   endtask

   task automatic add_frame(input logic [31:0] l, input logic [31:0] r, input int n, input bit expect_it);
      add_slot(0, l, n);
      add_slot(1, r, n);
      if (expect_it) begin
         exp_l.push_back(model(l, n, int'(i_wlen)));
         exp_r.push_back(model(r, n, int'(i_wlen)));
      end
   endtask

   // SD lags WS by one bit slot, as in I2S
   task automatic play();
      while (ws_q.size() > 0) begin
         @(posedge clk); #1;
         i_sck = 0;
         i_ws = ws_q.pop_front();
         i_sd = sd_prev;
         sd_prev = sd_q.pop_front();
         repeat (4) @(posedge clk);
         #1 i_sck = 1;
         repeat (4) @(posedge clk);
      end
      @(posedge clk); #1 i_sck = 0;
   endtask

   task automatic drain();
      repeat (40) @(posedge clk);
   endtask

   task automatic check_pairs();
      chk("npairs", 32'(n_got - base), 32'(exp_l.size()));
      for (int k = 0; k < exp_l.size() && base + k < n_got; k++) begin
         chk("pair_l", got_l[base + k], exp_l[k]);
         chk("pair_r", got_r[base + k], exp_r[k]);
      end
      base = n_got;
      exp_l.delete();
      exp_r.delete();
   endtask

   task automatic idle();
      rdy_mode = 1;
      drain();
      @(posedge clk); #1 i_en = 0;
      repeat (3) @(posedge clk);
      #1 i_clr = 1;
      @(posedge clk); #1 i_clr = 0;
   endtask

   task automatic std_run(input int w, input logic [31:0] l, input logic [31:0] r, input int n);
      i_wlen = WLW'(w);
      @(posedge clk); #1 i_en = 1;
      add_slot(1, 32'h5, 3);
      add_frame(l, r, n, 1);
      add_slot(0, 0, 2);
      play();
      drain();
      check_pairs();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_data_l", 32'(o_data_l), 0);
      chk("rst_data_r", 32'(o_data_r), 0);
      chk("rst_ovf", 32'(o_ovf), 0);
      chk("rst_err", 32'(o_err), 0);
      nrst = 1;
      repeat (2) @(posedge clk);

      std_run(16, 32'hA5C3, 32'h1234, 16);
      chk("err_full", 32'(o_err), 0);
      idle();

      std_run(12, 32'hA5C3, 32'hFFFF, 16);
      chk("err_w12", 32'(o_err), 0);
      idle();

      std_run(16, 32'hA5, 32'h3C, 8);
      chk("err_short", 32'(o_err), 1);
      @(posedge clk); #1 i_clr = 1;
      @(posedge clk); #1 i_clr = 0;
      chk("err_clr", 32'(o_err), 0);
      idle();

      for (int it = 0; it < 8; it++) begin
         int w = $urandom_range(0, 31);
         int n = $urandom_range(8, 24);
         logic [31:0] m = (32'd1 << n) - 1;
         i_wlen = WLW'(w);
         rdy_mode = 2;
         @(posedge clk); #1 i_en = 1;
         add_slot(1, $urandom, 3);
         add_frame($urandom & m, $urandom & m, n, 1);
         add_frame($urandom & m, $urandom & m, n, 1);
         add_slot(0, 0, 2);
         play();
         rdy_mode = 1;
         drain();
         check_pairs();
         chk("err_rand", 32'(o_err), 32'(n < eff_wlen(w)));
         chk("ovf_rand", 32'(o_ovf), 0);
         idle();
      end

      // enable in the middle of a right slot
      i_wlen = 16;
      add_slot(0, 32'h1111, 16);
      add_slot(1, 32'h22, 8);
      play();
      @(posedge clk); #1 i_en = 1;
      add_slot(1, 32'h33, 8);
      add_frame(32'hBEEF, 32'h0F0F, 16, 1);
      add_frame(32'h1357, 32'h8642, 16, 1);
      add_slot(0, 0, 2);
      play();
      drain();
      check_pairs();
      idle();

      // consumer stalls across two frames
      rdy_mode = 0;
      i_wlen = 16;
      @(posedge clk); #1 i_en = 1;
      add_slot(1, 0, 3);
      add_frame(32'hCAFE, 32'hF00D, 16, 1);
      add_frame(32'h1234, 32'h5678, 16, 0);
      add_slot(0, 0, 2);
      play();
      drain();
      chk("stall_valid", 32'(o_valid), 1);
      chk("stall_l", 32'(o_data_l), 32'hCAFE);
      chk("stall_r", 32'(o_data_r), 32'hF00D);
      chk("stall_ovf", 32'(o_ovf), 1);
      @(posedge clk); #1 rdy_mode = 1;
      @(posedge clk); #1 rdy_mode = 0;
      chk("pop_valid", 32'(o_valid), 0);
      check_pairs();
      idle();
      chk("ovf_clr", 32'(o_ovf), 0);

      // disable mid-left with a pair pending, then re-enable mid-right
      rdy_mode = 0;
      i_wlen = 16;
      @(posedge clk); #1 i_en = 1;
      add_slot(1, 0, 3);
      add_frame(32'h0A0A, 32'h0B0B, 16, 0);
      add_slot(0, 32'hFF, 8);
      play();
      chk("pend_valid", 32'(o_valid), 1);
      @(posedge clk); #1 i_en = 0;
      repeat (2) @(posedge clk);
      #1 chk("dis_valid", 32'(o_valid), 0);
      add_slot(0, 32'hFF, 8);
      add_slot(1, 32'hFF, 8);
      play();
      @(posedge clk); #1 i_en = 1;
      rdy_mode = 1;
      add_slot(1, 32'hFF, 8);
      add_frame(32'h8001, 32'h7FFE, 16, 1);
      add_frame(32'h00FF, 32'hFF00, 16, 1);
      add_slot(0, 0, 2);
      play();
      drain();
      check_pairs();
      chk("dis_ovf", 32'(o_ovf), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/i2s_rx_framer.md
# i2s_rx_framer

- I2S slave receive controller for the apb_i2s block.
- Takes asynchronous SCK/WS/SD pins through three signal_sync instances and sequences the synchronized edges through an alignment/channel state machine.
- Deserializes MSB-first left/right words and presents each complete stereo pair on a valid/ready interface to the APB register/FIFO side.
- Reports overflow and short-slot errors as sticky flags.

## Interface
- DATA_W, 16: maximum captured word width per channel (8..32).
- WL_W, $clog2(DATA_W+1): width of i_wlen.
- clk  in  1  system clock.
- nrst  in  1  reset, asynchronous, active-low.
- i_en  in  1  receiver enable; low forces DISABLED.
- i_wlen  in  WL_W  word length in bits; 0 or >DATA_W treated as DATA_W; sampled at each channel start.
- i_sck, i_ws, i_sd  in  1  raw asynchronous I2S pins.
- o_data_l, o_data_r  out  DATA_W  captured words, right-justified, upper bits zero.
- o_valid  out  1  pair available.
- i_ready  in  1  consumer accepts pair.
- o_ovf  out  1  sticky: completed pair dropped.
- o_err  out  1  sticky: slot shorter than word length.
- i_clr  in  1  clears o_ovf and o_err.

## Operation
- Synchronizers give sck_pe and ws_s/sd_s; all capture happens only on cycles with sck_pe=1.
- ws_prev holds WS sampled at the previous sck_pe.
- ws_chg = ws_s != ws_prev.
- States DISABLED, ALIGN, LEFT, RIGHT.
- DISABLED: entered on reset or when i_en=0. Shift register, bit counter, ws_prev and o_valid are cleared. Goes to ALIGN on the first cycle with i_en=1.
- ALIGN: waits for a sck_pe with ws_s=0 and ws_prev=1. On it, clears the counter and goes to LEFT. No data is captured in ALIGN.
- LEFT/RIGHT, per sck_pe, in this order:
  - 1. If the channel counter is below the latched wlen, shift in sd_s and increment the counter. This applies to the bit on the WS-change edge too, which is the LSB of the outgoing channel per I2S one-bit delay.
  - 2. If ws_chg, the channel ends. If the counter (after step 1) is below wlen, pad the word with zeros on the right to wlen bits and set o_err.
- LEFT end (WS 0->1): latch the word into a left holding register, clear the counter, latch i_wlen, go to RIGHT.
- RIGHT end (WS 1->0): complete the pair, clear the counter, latch i_wlen, go to LEFT.
  - If o_valid=0, or o_valid=1 with i_ready=1 in the same cycle: load o_data_l/o_data_r and set o_valid.
  - Otherwise drop the pair and set o_ovf.
- Bits beyond wlen within a slot are ignored.
- Handshake:
  - o_valid stays high and o_data_* stay stable until a cycle with i_ready=1.
  - o_valid drops the next cycle unless a new pair loads at that cycle.
- Sticky flags: i_clr clears them; a set in the same cycle as i_clr wins.
- i_en falling mid-frame: next cycle enters DISABLED, partial words are discarded, o_valid is cleared, sticky flags are kept.
- Reset values: all outputs 0, state DISABLED.

## Timing
- SCK high and low phases must each last at least 3 clk periods, and WS/SD must be stable at least 3 clk around the SCK rising edge.
- Synchronizer latency: sck_pe asserts 2 clk after the first clk edge that samples SCK high.
- o_valid rises 1 clk after the sck_pe on which WS 1->0 is detected.
- o_err/o_ovf set 1 clk after the causing sck_pe.
- Throughput: one pair per frame. Consumer may take up to a full frame before an overflow occurs.

## Structure
- apb_i2s_pkg holds:
  - the state enum (DISABLED, ALIGN, LEFT, RIGHT);
  - the DATA_W default;
  - the wlen normalization function (0 / >DATA_W -> DATA_W).
- Sub-module: signal_sync, instantiated three times (sck, ws, sd).
- Everything else (FSM, counter, shift and holding registers, output stage) lives in i2s_rx_framer.

## Test plan
- DATA_W=16, wlen=16, 16-bit slots carrying L=0xA5C3, R=0x1234 -> o_data_l=0xA5C3, o_data_r=0x1234, o_valid=1, o_err=0.
- wlen=12, 16-bit slots, L=0xA5C3, R=0xFFFF -> o_data_l=0x0A5C, o_data_r=0x0FFF.
- wlen=16, 8-bit slots carrying 0xA5/0x3C -> o_data_l=0xA500, o_data_r=0x3C00, o_err=1; i_clr -> o_err=0.
- Enable mid-right-slot -> no output until the first full L/R frame after a WS 1->0 edge; the first pair matches the transmitted data exactly.
- i_ready held 0 over two frames -> first pair stays on o_data_*, o_ovf=1; i_ready=1 for one cycle -> o_valid=0 next cycle.
- i_en=0 mid-left-slot, then re-enable -> o_valid=0; next pair is captured correctly after ALIGN; no stale bits.
